// File: rtl/cu_pipe.sv
// cu_pipe: pipelined RV32I-subset control unit (decode, ID/EX-EX/MEM-MEM/WB control, hazard stall/flush, multi-cycle MUL wait)
module cu_pipe #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LAT     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  input  logic [6:0]            opcode_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  branch_taken_i,
  output logic [3:0]            ex_alu_op_o,
  output logic                  ex_alusrc_o,
  output logic                  ex_opa_pc_o,
  output logic                  ex_branch_o,
  output logic                  ex_jump_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic                  wb_we_o,
  output logic [1:0]            wb_src_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic                  busy_o,
  output logic                  illegal_o
);
  localparam int CW       = MC_LAT > 2 ? $clog2(MC_LAT) : 1;
  localparam int CNT_INIT = MC_LAT > 1 ? MC_LAT - 2 : 0;
  typedef struct packed {
    logic [3:0]            alu_op;
    logic                  alusrc;
    logic                  opa_pc;
    logic                  branch;
    logic                  jump;
    logic                  mem_read;
    logic                  mem_write;
    logic                  we;
    logic [1:0]            wb_src;
    logic [REG_ADDR_W-1:0] rd;
  } ctl_t;
  typedef enum logic {RUN, MC_WAIT} state_t;
  ctl_t          dec, idex_q, idex_d, exmem_q, exmem_d, memwb_q, memwb_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          illegal_q, illegal_d;
  logic          use1, use2, ill, load_use, flush, wait_st;
  logic [3:0]    r_op;
  always_comb begin
    r_op = funct7_i == 7'b0000001 ? 4'd10 :
           funct3_i == 3'b000     ? (funct7_i[5] ? 4'd1 : 4'd0) :
           funct3_i == 3'b001     ? 4'd6 :
           funct3_i[2:1] == 2'b01 ? 4'd5 :
           funct3_i == 3'b100     ? 4'd4 :
           funct3_i == 3'b101     ? (funct7_i[5] ? 4'd8 : 4'd7) :
           funct3_i == 3'b110     ? 4'd3 : 4'd2;
    dec  = '0;
    use1 = 1'b0;
    use2 = 1'b0;
    ill  = 1'b0;
    if (valid_i) begin
      case (opcode_i)
        7'b0110011: begin dec.alu_op = r_op; dec.we = 1'b1; use1 = 1'b1; use2 = 1'b1; end
        7'b0010011: begin dec.alusrc = 1'b1; dec.we = 1'b1; use1 = 1'b1; end
        7'b0110111: begin dec.alu_op = 4'd9; dec.alusrc = 1'b1; dec.we = 1'b1; end
        7'b0010111: begin dec.opa_pc = 1'b1; dec.alusrc = 1'b1; dec.we = 1'b1; end
        7'b1100011: begin dec.alu_op = 4'd1; dec.branch = 1'b1; use1 = 1'b1; use2 = 1'b1; end
        7'b1101111: begin dec.jump = 1'b1; dec.opa_pc = 1'b1; dec.we = 1'b1; dec.wb_src = 2'd2; end
        7'b1100111: begin dec.jump = 1'b1; dec.alusrc = 1'b1; dec.we = 1'b1; dec.wb_src = 2'd2; use1 = 1'b1; end
        7'b0000011: begin dec.alusrc = 1'b1; dec.mem_read = 1'b1; dec.we = 1'b1; dec.wb_src = 2'd1; use1 = 1'b1; end
        7'b0100011: begin dec.alusrc = 1'b1; dec.mem_write = 1'b1; use1 = 1'b1; use2 = 1'b1; end
        default:    ill = 1'b1;
      endcase
    end
    dec.we = dec.we && rd_i != '0;
    dec.rd = dec.we ? rd_i : '0;
  end
  always_comb begin
    wait_st   = state_q == MC_WAIT;
    flush     = branch_taken_i && (idex_q.branch || idex_q.jump);
    load_use  = !wait_st && idex_q.mem_read && idex_q.rd != '0 &&
                ((use1 && rs1_i == idex_q.rd) || (use2 && rs2_i == idex_q.rd));
    stall_o   = !flush && (wait_st || load_use);
    flush_o   = flush;
    busy_o    = wait_st;
    idex_d    = flush ? '0 : wait_st ? idex_q : load_use ? '0 : dec;
    exmem_d   = wait_st ? '0 : idex_q;
    memwb_d   = exmem_q;
    illegal_d = ill && !stall_o && !flush;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (wait_st) begin
      state_d = cnt_q == '0 ? RUN : MC_WAIT;
      cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
    end else if (MC_LAT > 1 && idex_d.alu_op == 4'd10) begin
      state_d = MC_WAIT;
      cnt_d   = CW'(CNT_INIT);
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      idex_q    <= '0;
      exmem_q   <= '0;
      memwb_q   <= '0;
      state_q   <= RUN;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      idex_q    <= idex_d;
      exmem_q   <= exmem_d;
      memwb_q   <= memwb_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end
  assign ex_alu_op_o = idex_q.alu_op;
  assign ex_alusrc_o = idex_q.alusrc;
  assign ex_opa_pc_o = idex_q.opa_pc;
  assign ex_branch_o = idex_q.branch;
  assign ex_jump_o   = idex_q.jump;
  assign mem_read_o  = exmem_q.mem_read;
  assign mem_write_o = exmem_q.mem_write;
  assign wb_we_o     = memwb_q.we;
  assign wb_src_o    = memwb_q.wb_src;
  assign wb_rd_o     = memwb_q.rd;
  assign illegal_o   = illegal_q;
endmodule

// File: tb/tb_cu_pipe.sv
// tb_cu_pipe: directed self-checking bench for cu_pipe
module tb_cu_pipe;
  localparam logic [6:0] R = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111, AUI = 7'b0010111;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LD = 7'b0000011, ST = 7'b0100011;
  logic       clk = 1'b0, rst_n, valid, bt;
  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  logic [3:0] ex_alu_op;
  logic       ex_alusrc, ex_opa_pc, ex_branch, ex_jump, mem_read, mem_write, wb_we;
  logic [1:0] wb_src;
  logic [4:0] wb_rd;
  logic       stall, flush, busy, illegal;
  logic [21:0] all_o;
  int n_pass = 0, n_chk = 0;
  cu_pipe #(.REG_ADDR_W(5), .MC_LAT(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .opcode_i(opcode), .funct3_i(f3), .funct7_i(f7),
    .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .branch_taken_i(bt),
    .ex_alu_op_o(ex_alu_op), .ex_alusrc_o(ex_alusrc), .ex_opa_pc_o(ex_opa_pc), .ex_branch_o(ex_branch),
    .ex_jump_o(ex_jump), .mem_read_o(mem_read), .mem_write_o(mem_write), .wb_we_o(wb_we),
    .wb_src_o(wb_src), .wb_rd_o(wb_rd), .stall_o(stall), .flush_o(flush), .busy_o(busy), .illegal_o(illegal)
  );
  always #5 clk = ~clk;
  assign all_o = {ex_alu_op, ex_alusrc, ex_opa_pc, ex_branch, ex_jump, mem_read, mem_write,
                  wb_we, wb_src, wb_rd, stall, flush, busy, illegal};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic ins(input logic [6:0] op, input logic [2:0] a, input logic [6:0] b,
                     input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    valid = 1'b1; opcode = op; f3 = a; f7 = b; rs1 = s1; rs2 = s2; rd = d;
  endtask
  task automatic nop;
    valid = 1'b0; opcode = '0; f3 = '0; f7 = '0; rs1 = '0; rs2 = '0; rd = '0;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; bt = 1'b0;
    ins(OPI, 0, 0, 0, 0, 1);
    tick; tick;
    chk("reset_all", 32'(all_o), 0);
    rst_n = 1'b1;
    tick;
    chk("rel_alusrc", 32'(ex_alusrc), 1);
    chk("rel_aluop", 32'(ex_alu_op), 0);
    nop;
    tick;
    chk("lat_wb_early", 32'(wb_we), 0);
    tick;
    chk("lat_wb_we", 32'(wb_we), 1);
    chk("lat_wb_rd", 32'(wb_rd), 1);
    ins(LD, 2, 0, 1, 0, 5);
    tick;
    ins(R, 0, 7'h20, 5, 1, 6);
    #1;
    chk("lu_stall", 32'(stall), 1);
    chk("lu_noflush", 32'(flush), 0);
    tick;
    chk("lu_bubble", 32'(ex_alusrc), 0);
    chk("lu_release", 32'(stall), 0);
    chk("lu_memread", 32'(mem_read), 1);
    tick;
    chk("lu_sub_ex", 32'(ex_alu_op), 1);
    chk("lw_wb", 32'({wb_we, wb_src, wb_rd}), {1'b1, 2'd1, 5'd5});
    ins(LD, 2, 0, 1, 0, 0);
    tick;
    ins(R, 0, 7'h20, 0, 1, 6);
    #1;
    chk("lw_x0_nostall", 32'(stall), 0);
    ins(LD, 2, 0, 1, 0, 5);
    tick;
    ins(LUI, 0, 0, 5, 5, 5);
    #1;
    chk("lw_lui_nostall", 32'(stall), 0);
    tick;
    chk("lui_ex", 32'({ex_alu_op, ex_alusrc}), {4'd9, 1'b1});
    ins(LD, 2, 0, 1, 0, 7);
    tick;
    ins(ST, 2, 0, 1, 7, 0);
    #1;
    chk("lu_rs2_stall", 32'(stall), 1);
    tick; tick;
    chk("sw_ex", 32'(ex_alusrc), 1);
    ins(OPI, 0, 0, 1, 0, 2);
    tick;
    chk("sw_mem", 32'(mem_write), 1);
    bt = 1'b1;
    #1;
    chk("bt_ignored", 32'(flush), 0);
    bt = 1'b0;
    ins(BR, 0, 0, 1, 2, 0);
    tick;
    chk("beq_ex", 32'({ex_branch, ex_alu_op}), {1'b1, 4'd1});
    ins(OPI, 0, 0, 0, 0, 2);
    bt = 1'b1;
    #1;
    chk("beq_flush", 32'({flush, stall}), 2'b10);
    tick;
    bt = 1'b0;
    chk("beq_bubble", 32'({ex_alu_op, ex_alusrc, ex_opa_pc, ex_branch, ex_jump}), 0);
    ins(JAL, 0, 0, 0, 0, 1);
    tick;
    chk("jal_ex", 32'({ex_jump, ex_opa_pc}), 2'b11);
    ins(OPI, 0, 0, 0, 0, 2);
    bt = 1'b1;
    #1;
    chk("jal_flush", 32'(flush), 1);
    tick;
    bt = 1'b0;
    nop;
    chk("jal_bubble", 32'(ex_jump), 0);
    tick;
    chk("jal_wb", 32'({wb_we, wb_src, wb_rd}), {1'b1, 2'd2, 5'd1});
    ins(AUI, 0, 0, 0, 0, 8);
    tick;
    chk("auipc_ex", 32'({ex_alu_op, ex_alusrc, ex_opa_pc}), {4'd0, 2'b11});
    ins(JALR, 0, 0, 1, 0, 9);
    tick;
    chk("jalr_ex", 32'({ex_jump, ex_alusrc, ex_opa_pc}), 3'b110);
    ins(R, 5, 7'h20, 1, 2, 10);
    tick;
    chk("sra_ex", 32'(ex_alu_op), 8);
    ins(R, 7, 0, 1, 2, 11);
    tick;
    chk("and_ex", 32'(ex_alu_op), 2);
    ins(OPI, 0, 0, 1, 0, 0);
    tick;
    nop;
    tick; tick;
    chk("rd0_no_we", 32'(wb_we), 0);
    ins(R, 0, 7'h01, 1, 2, 3);
    tick;
    ins(OPI, 0, 0, 0, 0, 4);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mul_wait%0d", i), 32'({busy, stall, ex_alu_op}), {2'b11, 4'd10});
      tick;
    end
    chk("mul_last", 32'({busy, stall, ex_alu_op}), {2'b00, 4'd10});
    chk("mul_memnop", 32'(wb_we), 0);
    tick;
    nop;
    chk("mul_next", 32'({ex_alu_op, ex_alusrc}), {4'd0, 1'b1});
    chk("mul_memnop2", 32'(wb_we), 0);
    tick;
    chk("mul_wb", 32'({wb_we, wb_rd}), {1'b1, 5'd3});
    ins(7'h7F, 0, 0, 0, 0, 0);
    tick;
    valid = 1'b0;
    chk("ill_pulse", 32'(illegal), 1);
    chk("ill_nop", 32'({ex_alu_op, ex_alusrc, ex_opa_pc, ex_branch, ex_jump}), 0);
    tick;
    chk("ill_end", 32'(illegal), 0);
    ins(R, 0, 7'h01, 1, 2, 3);
    tick;
    chk("mul_busy", 32'(busy), 1);
    rst_n = 1'b0;
    nop;
    tick;
    chk("rst_wait", 32'({busy, stall, ex_alu_op}), 0);
    rst_n = 1'b1;
    tick;
    chk("rst_run", 32'(busy), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
